// File: rtl/mips_pkg.sv
// Shared definitions for the P6 MIPS core: next-PC select encodings,
// fetch reset constants and the branch-target helper.
package mips_pkg;

  typedef enum logic [2:0] {
    PCSEL_SEQ = 3'b000,
    PCSEL_B   = 3'b001,
    PCSEL_J   = 3'b010,
    PCSEL_JR  = 3'b011,
    PCSEL_BL  = 3'b100
  } pc_sel_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  // The target is relative to the delay-slot address (branch PC + 4).
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc.sv
// Combinational next-PC selection for the fetch stage.
module npc
  import mips_pkg::*;
(
  input  logic [31:0] PC_F,
  input  logic [31:0] PC_D,
  input  logic [31:0] instr_D,
  input  logic [31:0] RD1,
  input  logic [2:0]  PC_sel,
  input  logic        bw,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] j_pc;
  logic        unused_opcode;

  assign seq_pc        = PC_F + 32'd4;
  assign br_pc         = branch_target(PC_D, instr_D[15:0]);
  assign j_pc          = {PC_D[31:28], instr_D[25:0], 2'b00};
  assign unused_opcode = ^instr_D[31:26];

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    next_pc = seq_pc;
    case (pc_sel_e'(PC_sel))
      PCSEL_B:  next_pc = br_pc;
      PCSEL_J:  next_pc = j_pc;
      PCSEL_JR: next_pc = RD1;
      PCSEL_BL: next_pc = bw ? br_pc : seq_pc;
      default:  next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC mux and the IF/ID pipeline register.
// Branches resolve in D with one delay slot, annulled only by flush.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP      = mips_pkg::NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  PC_sel,
  input  logic        bw,
  input  logic        flush,
  input  logic [31:0] RD1,
  input  logic [31:0] instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic        valid_D,
  output logic        pc_misalign
);

  logic [31:0] next_pc;

  npc u_npc (
    .PC_F    (PC_F),
    .PC_D    (PC_D),
    .instr_D (instr_D),
    .RD1     (RD1),
    .PC_sel  (PC_sel),
    .bw      (bw),
    .next_pc (next_pc)
  );

  // Stall ignores PC_sel/flush entirely: the D operands are not final yet.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      PC_F    <= RESET_PC;
      instr_D <= NOP;
      PC_D    <= 32'h0;
      valid_D <= 1'b0;
    end else if (!stall) begin
      PC_F <= next_pc;
      PC_D <= PC_F;
      if (flush) begin
        instr_D <= NOP;
        valid_D <= 1'b0;
      end else begin
        instr_D <= instr_F;
        valid_D <= 1'b1;
      end
    end
  end

  assign pc_misalign = |PC_F[1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver pushes hand-computed expectations,
// a monitor pops and compares one entry after each rising edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, bw, flush;
  logic [2:0]  PC_sel;
  logic [31:0] RD1, instr_F;
  logic [31:0] PC_F, instr_D, PC_D;
  logic        valid_D, pc_misalign;

  typedef struct {
    string       name;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .PC_sel      (PC_sel),
    .bw          (bw),
    .flush       (flush),
    .RD1         (RD1),
    .instr_F     (instr_F),
    .PC_F        (PC_F),
    .instr_D     (instr_D),
    .PC_D        (PC_D),
    .valid_D     (valid_D),
    .pc_misalign (pc_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, req);
  endtask

  // Drive one cycle's inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic cyc(input string name, input logic rst, input logic stl, input logic fl,
                     input logic b, input logic [2:0] sel, input logic [31:0] rd1,
                     input logic [31:0] ins, input logic [31:0] e_pc, input logic [31:0] e_ins,
                     input logic [31:0] e_pcd, input logic e_v, input logic e_mis);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = stl; flush = fl; bw = b; PC_sel = sel; RD1 = rd1; instr_F = ins;
    e.name = name; e.pc_f = e_pc; e.instr_d = e_ins; e.pc_d = e_pcd; e.valid_d = e_v; e.mis = e_mis;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".PC_F"},    PC_F,    e.pc_f);
        check({e.name, ".instr_D"}, instr_D, e.instr_d);
        check({e.name, ".PC_D"},    PC_D,    e.pc_d);
        check({e.name, ".valid_D"}, {31'b0, valid_D},     {31'b0, e.valid_d});
        check({e.name, ".misalign"}, {31'b0, pc_misalign}, {31'b0, e.mis});
      end
    end
  end

  initial begin : driver
    int budget;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; bw = 1'b0; PC_sel = 3'b000;
    RD1 = 32'h0; instr_F = 32'h0;
    //  name        rst stl fl bw sel     RD1           instr_F       PC_F          instr_D       PC_D          v  mis
    cyc("rst0",     1, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0000_3000, 32'h0,        32'h0,        0, 0);
    cyc("rst1",     1, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0000_3000, 32'h0,        32'h0,        0, 0);
    cyc("seq0",     0, 0, 0, 0, 3'b000, 32'h0,        32'h2400_0001, 32'h0000_3004, 32'h2400_0001, 32'h0000_3000, 1, 0);
    cyc("seq1",     0, 0, 0, 0, 3'b000, 32'h0,        32'h2400_0002, 32'h0000_3008, 32'h2400_0002, 32'h0000_3004, 1, 0);
    cyc("beq_f",    0, 0, 0, 0, 3'b000, 32'h0,        32'h1000_FFFE, 32'h0000_300C, 32'h1000_FFFE, 32'h0000_3008, 1, 0);
    cyc("beq_tk",   0, 0, 0, 0, 3'b001, 32'h0,        32'h2401_0005, 32'h0000_3004, 32'h2401_0005, 32'h0000_300C, 1, 0);
    cyc("rst_mid",  1, 1, 1, 0, 3'b001, 32'h0,        32'hDEAD_BEEF, 32'h0000_3000, 32'h0,        32'h0,        0, 0);
    cyc("j_f",      0, 0, 0, 0, 3'b000, 32'h0,        32'h0800_0C10, 32'h0000_3004, 32'h0800_0C10, 32'h0000_3000, 1, 0);
    cyc("j_tk",     0, 0, 0, 0, 3'b010, 32'h0,        32'h2402_0007, 32'h0000_3040, 32'h2402_0007, 32'h0000_3004, 1, 0);
    cyc("jr_f",     0, 0, 0, 0, 3'b000, 32'h0,        32'h03E0_0008, 32'h0000_3044, 32'h03E0_0008, 32'h0000_3040, 1, 0);
    cyc("jr_mis",   0, 0, 0, 0, 3'b011, 32'h0000_3102, 32'h2403_0001, 32'h0000_3102, 32'h2403_0001, 32'h0000_3044, 1, 1);
    cyc("jr_back",  0, 0, 0, 0, 3'b011, 32'h0000_3200, 32'h1111_1111, 32'h0000_3200, 32'h1111_1111, 32'h0000_3102, 1, 0);
    cyc("bl_f",     0, 0, 0, 0, 3'b000, 32'h0,        32'h5000_0010, 32'h0000_3204, 32'h5000_0010, 32'h0000_3200, 1, 0);
    cyc("bl_bw",    0, 0, 0, 1, 3'b100, 32'h0,        32'h2404_0001, 32'h0000_3244, 32'h2404_0001, 32'h0000_3204, 1, 0);
    cyc("bl2_f",    0, 0, 0, 0, 3'b000, 32'h0,        32'h5000_0020, 32'h0000_3248, 32'h5000_0020, 32'h0000_3244, 1, 0);
    cyc("bl_flush", 0, 0, 1, 0, 3'b100, 32'h0,        32'h2405_0001, 32'h0000_324C, 32'h0,        32'h0000_3248, 0, 0);
    cyc("b3_f",     0, 0, 0, 0, 3'b000, 32'h0,        32'h1000_0003, 32'h0000_3250, 32'h1000_0003, 32'h0000_324C, 1, 0);
    cyc("stall0",   0, 1, 1, 0, 3'b001, 32'h0000_0100, 32'hAAAA_5555, 32'h0000_3250, 32'h1000_0003, 32'h0000_324C, 1, 0);
    cyc("stall1",   0, 1, 1, 1, 3'b011, 32'h0000_0200, 32'hAAAA_5555, 32'h0000_3250, 32'h1000_0003, 32'h0000_324C, 1, 0);
    cyc("stall2",   0, 1, 1, 0, 3'b010, 32'h0000_0300, 32'hAAAA_5555, 32'h0000_3250, 32'h1000_0003, 32'h0000_324C, 1, 0);
    cyc("b3_tk",    0, 0, 0, 0, 3'b001, 32'h0,        32'hAAAA_5555, 32'h0000_325C, 32'hAAAA_5555, 32'h0000_3250, 1, 0);
    cyc("bl3_f",    0, 0, 0, 0, 3'b000, 32'h0,        32'h5000_0001, 32'h0000_3260, 32'h5000_0001, 32'h0000_325C, 1, 0);
    cyc("fl_bw",    0, 0, 1, 1, 3'b100, 32'h0,        32'h1234_5678, 32'h0000_3264, 32'h0,        32'h0000_3260, 0, 0);
    cyc("jr_top",   0, 0, 0, 0, 3'b011, 32'hFFFF_FFFC, 32'h0123_4567, 32'hFFFF_FFFC, 32'h0123_4567, 32'h0000_3264, 1, 0);
    cyc("wrap",     0, 0, 0, 0, 3'b000, 32'h0,        32'h89AB_CDEF, 32'h0000_0000, 32'h89AB_CDEF, 32'hFFFF_FFFC, 1, 0);
    cyc("sel101",   0, 0, 0, 1, 3'b101, 32'h0000_0700, 32'h0F0F_0F0F, 32'h0000_0004, 32'h0F0F_0F0F, 32'h0000_0000, 1, 0);
    cyc("sel111",   0, 0, 0, 1, 3'b111, 32'h0000_0700, 32'h0000_0002, 32'h0000_0008, 32'h0000_0002, 32'h0000_0004, 1, 0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the P6 five-stage MIPS core. Consumes the D-stage branch unit outputs (`PC_sel`, `flush`, `bw`), computes the next PC, drives the instruction-memory address, and registers the fetched instruction and its PC into the D stage. Branches resolve in D with one architectural delay slot, which is annulled only by `flush`.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `NOP`, default 32'h0000_0000: instruction word inserted into IF/ID on flush and reset.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard-unit stall; holds the PC and IF/ID.
- `PC_sel` in 3: next-PC select from the branch unit.
- `bw` in 1: special branch (`PC_sel`=100) condition true.
- `flush` in 1: special branch condition false; annul the delay slot.
- `RD1` in 32: forwarded GPR[rs] in D; the `jr` target.
- `instr_F` in 32: instruction-memory read data for address `PC_F`; combinational read.
- `PC_F` out 32: current fetch PC and instruction-memory address.
- `instr_D` out 32: registered instruction in D.
- `PC_D` out 32: registered PC of `instr_D`.
- `valid_D` out 1: `instr_D` is a real instruction, not an inserted bubble.
- `pc_misalign` out 1: asserted when `PC_F[1:0]` != 0; combinational.

## Operation
- Next-PC selection, using `instr_D` and `PC_D`:
  - 000: `PC_F`+4.
  - 001: `PC_D`+4+(sext(`instr_D[15:0]`)<<2).
  - 010: {`PC_D[31:28]`, `instr_D[25:0]`, 2'b00}.
  - 011: `RD1`.
  - 100: if `bw`, the branch target as for 001; otherwise `PC_F`+4.
  - 101–111: treated as 000.
- Arithmetic:
  - All additions are 32-bit modulo 2^32.
  - Wrap-around is permitted.
  - No overflow flag is produced.
- `jr` to a misaligned `RD1`:
  - The value is loaded unchanged.
  - `pc_misalign` flags it; there is no trap in this block.
- Priority on each rising edge: `reset` > `stall` > `flush` > normal.
  - reset: `PC_F`=`RESET_PC`, `instr_D`=`NOP`, `PC_D`=0, `valid_D`=0.
  - stall=1:
    - `PC_F`, `instr_D`, `PC_D` and `valid_D` all hold.
    - `PC_sel`, `bw` and `flush` are ignored, because the D operands are not final.
  - flush=1, stall=0:
    - `PC_F` gets the next PC.
    - `instr_D`=`NOP`, `PC_D`=`PC_F`, `valid_D`=0.
    - This annuls the delay-slot instruction currently in F.
  - normal:
    - `PC_F` gets the next PC.
    - `instr_D`=`instr_F`, `PC_D`=`PC_F`, `valid_D`=1.
- `flush` and `bw` are both 1 (illegal): `flush` wins for IF/ID; next PC follows `bw`.
- No FSM beyond the PC/IF-ID registers. The delay slot is implicit: the instruction fetched in the cycle a branch is in D always enters D unless flushed.

## Timing
- Fetch latency: an instruction is visible on `instr_D` one cycle after `PC_F` addresses it.
- Branch resolution:
  - A branch in D in cycle n redirects `PC_F` at edge n+1.
  - The delay slot, fetched in cycle n, appears in D in cycle n+1 unless flushed.
- Stall: a branch held in D by `stall` takes effect on the first non-stalled edge, using the `RD1` value at that edge.
- Reset mid-operation: the next edge restores reset values regardless of `stall` or `flush`. The first fetch after reset deasserts is at `RESET_PC`.
- Outputs:
  - `PC_F`, `instr_D`, `PC_D` and `valid_D` are registered only.
  - `pc_misalign` is combinational from `PC_F`.

## Structure
- Shared package `mips_pkg` holds:
  - `PC_sel` encodings: `PCSEL_SEQ`=000, `PCSEL_B`=001, `PCSEL_J`=010, `PCSEL_JR`=011, `PCSEL_BL`=100.
  - `RESET_PC` and `NOP` constants.
- One combinational sub-module, `npc`: inputs `PC_F`, `PC_D`, `instr_D`, `RD1`, `PC_sel`, `bw`; output `next_pc`.
- The PC register and the IF/ID register live in `fetch_stage`.

## Test plan
- Reset held 2 cycles, then released:
  - During reset: `PC_F`=3000, `valid_D`=0, `instr_D`=0.
  - After release: `PC_F` steps 3004, 3008.
- Branch test:
  - `PC_D`=3008, `instr_D[15:0]`=FFFE, `PC_sel`=001: next `PC_F`=3008+4−8=3004.
  - The delay slot fetched at 300C reaches D with `valid_D`=1.
- Jump test:
  - `PC_sel`=010, `instr_D[25:0]`=0000C10, `PC_D`=3000: next `PC_F`=00003040.
  - `PC_sel`=011, `RD1`=00003102: `PC_F`=3102 and `pc_misalign`=1.
- `PC_sel`=100 tests:
  - With `bw`=1: `PC_F` gets the branch target and the delay slot has `valid_D`=1.
  - With `flush`=1: `PC_F`+4, `instr_D`=`NOP`, `valid_D`=0.
- Stall and wrap:
  - `stall`=1 for 3 cycles together with `flush`=1: all outputs hold and the flush is ignored.
  - `PC_F`=FFFFFFFC with `PC_sel`=000: next `PC_F`=00000000.
